// File: rtl/shift_sequencer_if.sv
// Request/result bus and shifter-drive bus for shift_sequencer; no storage, no latency.
// Backpressure: none on the bus itself; the controller drops start while busy.
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (output start, op, amt, din, input busy, done, dout);
    modport slave  (input start, op, amt, din, output busy, done, dout);
endinterface

interface shifter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] sh_in;
    logic [1:0]       sh_op;
    logic [WIDTH-1:0] sh_out;

    modport ctrl (output sh_in, sh_op, input sh_out);
    modport unit (input sh_in, sh_op, output sh_out);
endinterface

// File: rtl/shift_sequencer.sv
// Iterates an external combinational 1-bit shifter amt times; done pulses amt+1 cycles after start (1 cycle for null ops).
// Backpressure: start is ignored while busy (SHIFT and DONE); requests are not queued.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    shift_sequencer_if.slave     bus,
    shifter_if.ctrl              shf
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_dout;
    logic             w_null_op;
    logic             w_last_step;

    // A zero amount or the none opcode completes without touching the shifter.
    assign w_null_op   = (bus.op == 2'b00) || (bus.amt == '0);
    assign w_last_step = (r_cnt == AMT_W'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_null_op ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_step) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= bus.din;
                        r_op  <= bus.op;
                        r_cnt <= bus.amt;
                        if (w_null_op) begin
                            r_dout <= bus.din;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= shf.sh_out;
                    r_cnt <= r_cnt - AMT_W'(1);
                    if (w_last_step) begin
                        r_dout <= shf.sh_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shifter sits in pass-through whenever it is not being stepped.
    assign shf.sh_in = r_acc;
    assign shf.sh_op = (r_state == S_SHIFT) ? r_op : 2'b00;

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.dout  = r_dout;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 1-bit shifter on the side port.
module tb_shift_sequencer;
    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   n_done;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();
    shifter_if #(.WIDTH(WIDTH)) shf ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .shf     (shf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (shf.sh_op)
            2'b01:   shf.sh_out = {shf.sh_in[WIDTH-2:0], 1'b0};
            2'b10:   shf.sh_out = {1'b0, shf.sh_in[WIDTH-1:1]};
            2'b11:   shf.sh_out = {shf.sh_in[WIDTH-1], shf.sh_in[WIDTH-1:1]};
            default: shf.sh_out = shf.sh_in;
        endcase
    end

    always @(negedge clk) begin
        if (bus.done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to completion; optionally pulses a
    // competing start during SHIFT and during DONE, which must be dropped.
    task automatic run_op(input string tag, input logic [15:0] din, input logic [1:0] op,
                          input logic [3:0] amt, input logic [15:0] exp_dout,
                          input int exp_n, input bit intrude);
        int cycles;
        int sh_cycles;
        int op_bad;
        int done0;
        cycles    = 0;
        sh_cycles = 0;
        op_bad    = 0;
        done0     = n_done;
        bus.start = 1'b1;
        bus.din   = din;
        bus.op    = op;
        bus.amt   = amt;
        tick();
        bus.start = 1'b0;
        bus.din   = ~din;
        bus.op    = ~op;
        bus.amt   = amt ^ 4'h5;
        while (!bus.done && cycles < 40) begin
            if (shf.sh_op != 2'b00) begin
                sh_cycles++;
                if (shf.sh_op != op) op_bad++;
            end
            if (intrude && cycles == 1) begin
                bus.start = 1'b1;
                bus.din   = 16'hAAAA;
                bus.op    = 2'b01;
                bus.amt   = 4'h4;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cycles++;
        end
        chk({tag, ".latency"}, 32'(cycles), 32'(exp_n));
        chk({tag, ".shift_cycles"}, 32'(sh_cycles), 32'(exp_n));
        chk({tag, ".sh_op_value"}, 32'(op_bad), 32'd0);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(exp_dout));
        chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd1);
        if (intrude) begin
            bus.start = 1'b1;
            bus.din   = 16'hAAAA;
            bus.op    = 2'b01;
            bus.amt   = 4'h4;
        end
        tick();
        bus.start = 1'b0;
        chk({tag, ".done_drop"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk({tag, ".done_pulses"}, 32'(n_done - done0), 32'd1);
        chk({tag, ".dout_held"}, 32'(bus.dout), 32'(exp_dout));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        n_done    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.amt   = 4'h0;
        bus.din   = 16'h0000;
        tick();
        tick();
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.dout", 32'(bus.dout), 32'h0000);
        chk("reset.sh_op", 32'(shf.sh_op), 32'd0);
        chk("reset.sh_in", 32'(shf.sh_in), 32'h0000);
        rst_n = 1'b1;
        tick();

        run_op("lsl4",    16'hF0CF, 2'b01, 4'd4,  16'h0CF0, 4,  1'b0);
        run_op("asr3",    16'hF0CF, 2'b11, 4'd3,  16'hFE19, 3,  1'b0);
        run_op("lsr15",   16'h8000, 2'b10, 4'd15, 16'h0001, 15, 1'b0);
        run_op("asr15",   16'h8000, 2'b11, 4'd15, 16'hFFFF, 15, 1'b0);
        run_op("lsl15",   16'h0001, 2'b01, 4'd15, 16'h8000, 15, 1'b0);
        run_op("amt0",    16'h1234, 2'b10, 4'd0,  16'h1234, 0,  1'b0);
        run_op("opnone",  16'h1234, 2'b00, 4'd7,  16'h1234, 0,  1'b0);
        run_op("intrude", 16'hF0CF, 2'b01, 4'd4,  16'h0CF0, 4,  1'b1);

        // Reset lands on the second SHIFT cycle of a four-step shift.
        bus.start = 1'b1;
        bus.din   = 16'hF0CF;
        bus.op    = 2'b01;
        bus.amt   = 4'd4;
        tick();
        bus.start = 1'b0;
        chk("midrst.shift1", 32'(shf.sh_op), 32'd1);
        tick();
        chk("midrst.shift2", 32'(shf.sh_op), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        chk("midrst.dout", 32'(bus.dout), 32'h0000);
        chk("midrst.sh_op", 32'(shf.sh_op), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op("postrst", 16'h0003, 2'b11, 4'd1, 16'h0001, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
